ccip_wr_buffer: RTL and testbench

CCIP_WR_BUFFER -- requirements
Module: ccip_wr_buffer

---
 rtl/ccip_wr_buffer.sv | 154 +++++++++++++++
 tb/tb_ccip_wr_buffer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_wr_buffer.sv
// ccip_wr_buffer
//   Decouples a solver's cache-line write stream from CCI-P TX channel 1.
//   Requests are queued in a DEPTH-entry FIFO and issued as single-cycle
//   registered write pulses whenever the channel is not almost-full. Each
//   issued write carries a 16-bit sequence tag in c1_mdata.
//
//   Optional feature macro: CCIP_WR_BUF_CREDIT_EN
//     defined   - write responses are counted; at most MAX_OUTSTANDING writes
//                 may be unacknowledged, and a stray response sets a sticky
//                 rsp_underflow flag.
//     undefined - no credit tracking; outstanding/rsp_underflow read as 0 and
//                 rx_c1_wr_rsp is ignored.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid/in_ready     : solver request handshake
//   in_addr, in_data      : 42-bit line address, 512-bit payload
//   c1_almfull            : TX channel 1 back-pressure
//   c1_valid/addr/data    : registered write request toward channel 1
//   c1_mdata              : registered sequence tag
//   rx_c1_wr_rsp          : one write response this cycle
//   outstanding           : issued writes not yet acknowledged
//   idle                  : nothing buffered, nothing in flight
//   rsp_underflow         : sticky, response seen with nothing outstanding
module ccip_wr_buffer #(
  parameter int DEPTH           = 8,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [41:0]  in_addr,
  input  logic [511:0] in_data,
  input  logic         c1_almfull,
  output logic         c1_valid,
  output logic [41:0]  c1_addr,
  output logic [511:0] c1_data,
  output logic [15:0]  c1_mdata,
  input  logic         rx_c1_wr_rsp,
  output logic [9:0]   outstanding,
  output logic         idle,
  output logic         rsp_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [553:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_c1_valid;
  logic [41:0]   r_c1_addr;
  logic [511:0]  r_c1_data;
  logic [15:0]   r_c1_mdata;
  logic [15:0]   r_tag;

  logic w_push;
  logic w_pop;
  logic w_credit_ok;

  // in_ready looks only at the current count, so a full FIFO refuses a push
  // even in a cycle where an entry is leaving.
  assign in_ready = (r_count < CW'(DEPTH));
  assign w_push   = in_valid & in_ready;
  assign w_pop    = (r_count != '0) & ~c1_almfull & w_credit_ok;

  // Storage has no reset; entries are only ever read when count says they
  // are valid, so stale contents after reset are harmless.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= {in_addr, in_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_c1_valid <= 1'b0;
      r_c1_addr  <= '0;
      r_c1_data  <= '0;
      r_c1_mdata <= '0;
      r_tag      <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // The c1_* registers are the registered read port of the FIFO; a word
      // written at edge k is visible here after edge k+1.
      r_c1_valid <= w_pop;
      if (w_pop) begin
        {r_c1_addr, r_c1_data} <= r_mem[r_rd_ptr];
        r_c1_mdata             <= r_tag;
        r_tag                  <= r_tag + 16'd1;
        r_rd_ptr               <= r_rd_ptr + AW'(1);
      end
    end
  end

  assign c1_valid = r_c1_valid;
  assign c1_addr  = r_c1_addr;
  assign c1_data  = r_c1_data;
  assign c1_mdata = r_c1_mdata;

`ifdef CCIP_WR_BUF_CREDIT_EN
  logic [9:0] r_outstanding;
  logic       r_rsp_underflow;

  assign w_credit_ok = (r_outstanding != 10'(MAX_OUTSTANDING));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outstanding   <= '0;
      r_rsp_underflow <= 1'b0;
    end else begin
      case ({w_pop, rx_c1_wr_rsp})
        2'b10: r_outstanding <= r_outstanding + 10'd1;
        2'b01: begin
          // A response with nothing in flight is a protocol error: flag it
          // and keep the counter pinned at zero.
          if (r_outstanding == '0) begin
            r_rsp_underflow <= 1'b1;
          end else begin
            r_outstanding <= r_outstanding - 10'd1;
          end
        end
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign outstanding   = r_outstanding;
  assign rsp_underflow = r_rsp_underflow;
`else
  logic w_unused_rsp;

  assign w_credit_ok   = 1'b1;
  assign outstanding   = '0;
  assign rsp_underflow = 1'b0;
  assign w_unused_rsp  = rx_c1_wr_rsp | (MAX_OUTSTANDING == 0);
`endif

  assign idle = (r_count == '0) & ~r_c1_valid & (outstanding == '0);

endmodule

// File: tb/tb_ccip_wr_buffer.sv
module tb_ccip_wr_buffer;
  localparam int DEPTH   = 8;
  localparam int MAX_OUT = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [41:0]  in_addr = '0;
  logic [511:0] in_data = '0;
  logic         c1_almfull = 1'b0;
  logic         c1_valid;
  logic [41:0]  c1_addr;
  logic [511:0] c1_data;
  logic [15:0]  c1_mdata;
  logic         rx_c1_wr_rsp;
  logic [9:0]   outstanding;
  logic         idle;
  logic         rsp_underflow;

  logic rsp_man = 1'b0;
  logic auto_rsp = 1'b1;
  logic verbose = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;

  // Auto-responder acknowledges each issued write in the cycle after it.
  assign rx_c1_wr_rsp = rsp_man | (auto_rsp & c1_valid);

  ccip_wr_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data),
    .c1_almfull(c1_almfull),
    .c1_valid(c1_valid), .c1_addr(c1_addr), .c1_data(c1_data), .c1_mdata(c1_mdata),
    .rx_c1_wr_rsp(rx_c1_wr_rsp),
    .outstanding(outstanding), .idle(idle), .rsp_underflow(rsp_underflow)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [511:0] mkdata(input logic [41:0] a);
    logic [63:0] w;
    w = {22'h0, a} ^ 64'hC3A5_0F1E_5A5A_9669;
    return {w, ~w, w, ~w, w, ~w, w, ~w};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; outputs are sampled there.
  task automatic cyc();
    @(negedge clk);
    if (c1_valid === 1'b1) begin
      pulses++;
      if (verbose) $display("c1 write addr=%h mdata=%h outstanding=%0d", c1_addr, c1_mdata, outstanding);
    end
  endtask

  task automatic push_set(input logic [41:0] a);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = mkdata(a);
  endtask

  initial begin
    int          bad;
    int          wrap_seen;
    int          p0;
    logic [15:0] tag_exp;
    logic [15:0] prev;
    logic [41:0] a;
    logic [41:0] e;

    // ---------------- reset state ----------------
    #1 reset = 1'b1;
    cyc(); cyc();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_c1_valid", c1_valid, 0);
    chk("rst_mdata", c1_mdata, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_underflow", rsp_underflow, 0);
    reset = 1'b0;

    // ---------------- three pushes, in-order issue ----------------
    push_set(42'h10);
    cyc(); chk("t3_lat_c1_valid", c1_valid, 0);
    push_set(42'h11);
    cyc(); chk("t3_p0_valid", c1_valid, 1); chk("t3_p0_addr", c1_addr, 42'h10);
    chk("t3_p0_mdata", c1_mdata, 0); chk("t3_p0_data", c1_data === mkdata(42'h10), 1);
    push_set(42'h12);
    cyc(); chk("t3_p1_valid", c1_valid, 1); chk("t3_p1_addr", c1_addr, 42'h11); chk("t3_p1_mdata", c1_mdata, 1);
    in_valid = 1'b0;
    cyc(); chk("t3_p2_valid", c1_valid, 1); chk("t3_p2_addr", c1_addr, 42'h12); chk("t3_p2_mdata", c1_mdata, 2);
    cyc(); chk("t3_end_valid", c1_valid, 0); chk("t3_end_idle", idle, 1);

    // ---------------- fill under almost-full, then drain ----------------
    c1_almfull = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("full_in_ready", in_ready, (i < DEPTH) ? 1 : 0);
      push_set(42'h20 + 42'(i));
      cyc();
    end
    in_valid = 1'b0;
    chk("full_in_ready_low", in_ready, 0);
    chk("full_c1_valid", c1_valid, 0);
    cyc();
    chk("full_c1_valid_hold", c1_valid, 0);
    c1_almfull = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cyc();
      chk("drain_valid", c1_valid, 1);
      chk("drain_addr", c1_addr, 42'h20 + 42'(i));
      chk("drain_mdata", c1_mdata, 3 + i);
      if (i == 0) chk("drain_in_ready", in_ready, 1);
    end
    cyc(); chk("drain_end_valid", c1_valid, 0); chk("drain_end_idle", idle, 1);

    // ---------------- credit handling ----------------
    auto_rsp = 1'b0;
`ifdef CCIP_WR_BUF_CREDIT_EN
    p0 = pulses;
    for (int i = 0; i < 6; i++) begin
      push_set(42'h50 + 42'(i));
      cyc();
    end
    in_valid = 1'b0;
    repeat (4) cyc();
    chk("cr_issued4", pulses - p0, 4);
    chk("cr_out4", outstanding, 4);
    chk("cr_held_valid", c1_valid, 0);
    rsp_man = 1'b1; cyc(); cyc(); rsp_man = 1'b0;
    repeat (3) cyc();
    chk("cr_issued6", pulses - p0, 6);
    chk("cr_out4b", outstanding, 4);
    chk("cr_not_idle", idle, 0);
    rsp_man = 1'b1; repeat (4) cyc(); rsp_man = 1'b0;
    cyc();
    chk("cr_out0", outstanding, 0);
    chk("cr_idle", idle, 1);
    chk("cr_no_underflow", rsp_underflow, 0);

    rsp_man = 1'b1; cyc(); rsp_man = 1'b0;
    chk("uf_set", rsp_underflow, 1);
    chk("uf_out0", outstanding, 0);
    push_set(42'h60); cyc();
    push_set(42'h61); cyc();
    in_valid = 1'b0; cyc(); cyc();
    chk("sim_out2", outstanding, 2);
    push_set(42'h62); cyc();
    in_valid = 1'b0; rsp_man = 1'b1; cyc(); rsp_man = 1'b0;
    chk("sim_pop_valid", c1_valid, 1);
    chk("sim_pop_addr", c1_addr, 42'h62);
    chk("sim_out_same", outstanding, 2);
    cyc();
    chk("sim_out_hold", outstanding, 2);
    chk("uf_sticky", rsp_underflow, 1);
`else
    rsp_man = 1'b1; cyc(); rsp_man = 1'b0;
    cyc();
    chk("nocr_underflow", rsp_underflow, 0);
    chk("nocr_out", outstanding, 0);
    chk("nocr_idle", idle, 1);
    p0 = pulses;
    for (int i = 0; i < 6; i++) begin
      push_set(42'h50 + 42'(i));
      cyc();
    end
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("nocr_issued6", pulses - p0, 6);
    chk("nocr_out_after", outstanding, 0);
`endif
    auto_rsp = 1'b1;

    // ---------------- asynchronous reset mid-burst ----------------
    c1_almfull = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_set(42'h30 + 42'(i));
      cyc();
    end
    in_valid = 1'b0;
    c1_almfull = 1'b0;
    cyc();
    chk("ar_pre_valid", c1_valid, 1);
    chk("ar_pre_addr", c1_addr, 42'h30);
    #2 reset = 1'b1;
    #1;
    chk("ar_c1_valid", c1_valid, 0);
    chk("ar_idle", idle, 1);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_out", outstanding, 0);
    chk("ar_mdata", c1_mdata, 0);
    chk("ar_addr", c1_addr, 0);
    chk("ar_underflow", rsp_underflow, 0);
    push_set(42'h99);
    rsp_man = 1'b1;
    cyc(); cyc();
    chk("ar_hold_idle", idle, 1);
    chk("ar_hold_in_ready", in_ready, 1);
    chk("ar_hold_underflow", rsp_underflow, 0);
    in_valid = 1'b0;
    rsp_man = 1'b0;
    reset = 1'b0;
    cyc();
    chk("ar_post_valid", c1_valid, 0);
    chk("ar_post_idle", idle, 1);
    push_set(42'h40);
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("ar_first_valid", c1_valid, 1);
    chk("ar_first_addr", c1_addr, 42'h40);
    chk("ar_first_mdata", c1_mdata, 0);
    tag_exp = 16'd1;

    // ---------------- pointer wrap over 20 full-FIFO rounds ----------------
    bad = 0;
    a = 42'h1000;
    e = 42'h1000;
    for (int c = 0; c < 20; c++) begin
      c1_almfull = 1'b1;
      for (int j = 0; j < DEPTH; j++) begin
        push_set(a);
        a = a + 42'd1;
        cyc();
      end
      in_valid = 1'b0;
      if (in_ready !== 1'b0) bad++;
      c1_almfull = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        cyc();
        if (!(c1_valid === 1'b1 && c1_addr === e && c1_mdata === tag_exp)) bad++;
        e = e + 42'd1;
        tag_exp = tag_exp + 16'd1;
      end
      cyc();
      if (c1_valid !== 1'b0) bad++;
    end
    $display("pointer wrap: 20 rounds of %0d entries, last addr=%h", DEPTH, e - 42'd1);
    chk("ptr_wrap_bad", bad, 0);

    // ---------------- 65537 pops, tag wrap ----------------
    verbose = 1'b0;
    bad = 0;
    wrap_seen = 0;
    prev = tag_exp;
    a = 42'h2_0000_0000;
    push_set(a);
    cyc();
    for (int i = 0; i < 65537; i++) begin
      push_set(a + 42'd1);
      cyc();
      if (!(c1_valid === 1'b1 && c1_addr === a && c1_mdata === tag_exp && c1_data === mkdata(a))) bad++;
      if (prev == 16'hFFFF && c1_mdata == 16'h0000) wrap_seen++;
      prev = c1_mdata;
      tag_exp = tag_exp + 16'd1;
      a = a + 42'd1;
    end
    in_valid = 1'b0;
    cyc();
    verbose = 1'b1;
    $display("tag wrap: 65538 pops streamed, last mdata=%h", c1_mdata);
    chk("wrap_stream_bad", bad, 0);
    chk("wrap_seen_once", wrap_seen, 1);
    chk("wrap_last_addr", c1_addr, a);
    chk("wrap_last_mdata", c1_mdata, tag_exp);
    cyc();
    chk("wrap_end_idle", idle, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
